// File: rtl/grid_renderer_pipe_if.sv
// Pixel-stream bundle for grid_renderer_pipe: VGA position and board state
// flow into the renderer, registered colour and blink phase flow back out.
interface grid_renderer_pipe_if #(
   parameter int ROWS = 5,
   parameter int COLS = 10
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic                   pixel_en;
   logic [9:0]             hs;
   logic [9:0]             vs;
   logic [ROWS*COLS*3-1:0] states_flat;
   logic [RW-1:0]          cursor_row;
   logic [CW-1:0]          cursor_col;
   logic                   cursor_en;
   logic [7:0]             r;
   logic [7:0]             g;
   logic [7:0]             b;
   logic                   rgb_valid;
   logic                   blink;

   // Source side: timing controller plus board-state owner.
   modport master (
      output pixel_en, hs, vs, states_flat, cursor_row, cursor_col, cursor_en,
      input  r, g, b, rgb_valid, blink
   );

   // Renderer side.
   modport slave (
      input  pixel_en, hs, vs, states_flat, cursor_row, cursor_col, cursor_en,
      output r, g, b, rgb_valid, blink
   );
endinterface

// File: rtl/grid_renderer_pipe.sv
// Board renderer: tracks the cell under the beam with incremental counters,
// snapshots board/cursor state at frame start, and emits registered RGB two
// cycles after each pixel is presented.
module grid_renderer_pipe #(
   parameter int ROWS         = 5,
   parameter int COLS         = 10,
   parameter int CELL_W       = 64,
   parameter int CELL_H       = 96,
   parameter int LINE_W       = 5,
   parameter int DIV_COL      = 5,
   parameter int DIV_W        = 10,
   parameter int BLINK_FRAMES = 30
) (
   input logic                 clk,
   input logic                 reset,
   grid_renderer_pipe_if.slave bus
);
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int XOW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int YOW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
   localparam int XCW = $clog2(COLS + 1);   // xcol saturates at COLS
   localparam int YRW = $clog2(ROWS + 1);   // yrow saturates at ROWS
   localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef logic [ROWS-1:0][COLS-1:0][2:0] board_t;

   function automatic logic [23:0] palette(input logic [2:0] code);
      logic [23:0] c;
      case (code)
         3'd0:    c = 24'h000080;
         3'd1:    c = 24'h808080;
         3'd2:    c = 24'hFF0000;
         3'd3:    c = 24'hFFFFFF;
         3'd4:    c = 24'h800000;
         3'd5:    c = 24'h00FF00;
         3'd6:    c = 24'hFFFF00;
         default: c = 24'hFF00FF;
      endcase
      return c;
   endfunction

   logic line_start;
   logic frame_start;
   assign line_start  = bus.pixel_en && (bus.hs == 10'd0);
   assign frame_start = line_start && (bus.vs == 10'd0);

   // Counter registers hold the position of the most recent visible pixel;
   // the *_c values are the position of the pixel on the bus this cycle.
   logic [XOW-1:0] xoff_q, xoff_c;
   logic [XCW-1:0] xcol_q, xcol_c;
   logic [YOW-1:0] yoff_q, yoff_c;
   logic [YRW-1:0] yrow_q, yrow_c;

   board_t         board_q, board_c;
   logic [RW-1:0]  crow_q, crow_c;
   logic [CW-1:0]  ccol_q, ccol_c;
   logic           cen_q, cen_c;

   logic [FCW-1:0] fcnt_q, fcnt_c;
   logic           blink_q, blink_c;

   // Horizontal position of the presented pixel: restart at hs==0, else step.
   always_comb begin
      xoff_c = xoff_q;
      xcol_c = xcol_q;
      if (line_start) begin
         xoff_c = '0;
         xcol_c = '0;
      end else if (bus.pixel_en) begin
         if (xoff_q == XOW'(CELL_W - 1)) begin
            xoff_c = '0;
            if (xcol_q != XCW'(COLS)) xcol_c = xcol_q + 1'b1;
         end else begin
            xoff_c = xoff_q + 1'b1;
         end
      end
   end

   // Vertical position: only the first pixel of a line moves it.
   always_comb begin
      yoff_c = yoff_q;
      yrow_c = yrow_q;
      if (line_start) begin
         if (bus.vs == 10'd0) begin
            yoff_c = '0;
            yrow_c = '0;
         end else if (yoff_q == YOW'(CELL_H - 1)) begin
            yoff_c = '0;
            if (yrow_q != YRW'(ROWS)) yrow_c = yrow_q + 1'b1;
         end else begin
            yoff_c = yoff_q + 1'b1;
         end
      end
   end

   // Snapshot and blink phase, bypassed on frame start so the first pixel of
   // a frame already sees the freshly latched state.
   always_comb begin
      board_c = board_q;
      crow_c  = crow_q;
      ccol_c  = ccol_q;
      cen_c   = cen_q;
      fcnt_c  = fcnt_q;
      blink_c = blink_q;
      if (frame_start) begin
         board_c = bus.states_flat;
         crow_c  = bus.cursor_row;
         ccol_c  = bus.cursor_col;
         cen_c   = bus.cursor_en;
         if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
            fcnt_c  = '0;
            blink_c = ~blink_q;
         end else begin
            fcnt_c = fcnt_q + 1'b1;
         end
      end
   end

   // Position, snapshot and frame-counter state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         xoff_q  <= '0;
         xcol_q  <= '0;
         yoff_q  <= '0;
         yrow_q  <= '0;
         board_q <= '0;
         crow_q  <= '0;
         ccol_q  <= '0;
         cen_q   <= 1'b0;
         fcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         xoff_q  <= xoff_c;
         xcol_q  <= xcol_c;
         yoff_q  <= yoff_c;
         yrow_q  <= yrow_c;
         board_q <= board_c;
         crow_q  <= crow_c;
         ccol_q  <= ccol_c;
         cen_q   <= cen_c;
         fcnt_q  <= fcnt_c;
         blink_q <= blink_c;
      end
   end

   // Cell lookup for the presented pixel; out-of-grid positions never index
   // the board and never match the cursor.
   logic       in_grid_c;
   logic [2:0] code_c;
   logic       hit_c;
   always_comb begin
      in_grid_c = (xcol_c < XCW'(COLS)) && (yrow_c < YRW'(ROWS));
      code_c    = '0;
      hit_c     = 1'b0;
      if (in_grid_c) begin
         code_c = board_c[RW'(yrow_c)][CW'(xcol_c)];
         hit_c  = cen_c && blink_c &&
                  (32'(yrow_c) == 32'(crow_c)) && (32'(xcol_c) == 32'(ccol_c));
      end
   end

   // Stage 1: position within the cell, cell code and cursor match.
   logic           s1_in;
   logic [XOW-1:0] s1_xoff;
   logic [YOW-1:0] s1_yoff;
   logic [XCW-1:0] s1_xcol;
   logic [2:0]     s1_code;
   logic           s1_hit;
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_in   <= 1'b0;
         s1_xoff <= '0;
         s1_yoff <= '0;
         s1_xcol <= '0;
         s1_code <= '0;
         s1_hit  <= 1'b0;
      end else begin
         s1_in   <= bus.pixel_en && in_grid_c;
         s1_xoff <= xoff_c;
         s1_yoff <= yoff_c;
         s1_xcol <= xcol_c;
         s1_code <= code_c;
         s1_hit  <= hit_c;
      end
   end

   // Colour priority: blank, division band, grid line, cursor, cell palette.
   logic [23:0] rgb_c;
   always_comb begin
      rgb_c = 24'h000000;
      if (s1_in) begin
         if ((32'(s1_xcol) == DIV_COL) && (32'(s1_xoff) < DIV_W))
            rgb_c = 24'h00FFFF;
         else if ((32'(s1_xoff) < LINE_W) || (32'(s1_yoff) < LINE_W))
            rgb_c = 24'h202020;
         else if (s1_hit)
            rgb_c = 24'hFFA500;
         else
            rgb_c = palette(s1_code);
      end
   end

   // Stage 2: registered colour plus the pixel_en delay line.
   logic [23:0] rgb_q;
   logic [2:1]  vld_pipe;
   always_ff @(posedge clk) begin
      if (!reset) begin
         rgb_q    <= '0;
         vld_pipe <= '0;
      end else begin
         rgb_q    <= rgb_c;
         vld_pipe <= {vld_pipe[1], bus.pixel_en};
      end
   end

   assign bus.r         = rgb_q[23:16];
   assign bus.g         = rgb_q[15:8];
   assign bus.b         = rgb_q[7:0];
   assign bus.rgb_valid = vld_pipe[2];
   assign bus.blink     = blink_q;
endmodule

// File: tb/tb_grid_renderer_pipe.sv
// Bench for grid_renderer_pipe: drives short synthetic frames with random
// gaps and input churn, predicts every output cycle from a cell-arithmetic
// model, and adds fixed colour checks at the interesting pixels.
module tb_grid_renderer_pipe;
   localparam int ROWS = 5, COLS = 10, CELL_W = 64, CELL_H = 96, LINE_W = 5;
   localparam int DIV_COL = 5, DIV_W = 10, BLINK_FRAMES = 2;
   localparam int NB = ROWS * COLS * 3;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   grid_renderer_pipe_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   grid_renderer_pipe #(
      .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H), .LINE_W(LINE_W),
      .DIV_COL(DIV_COL), .DIV_W(DIV_W), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference state
   logic [NB-1:0] m_states = '0;
   bit            m_cen = 0;
   int            m_crow = 0, m_ccol = 0, m_fcnt = 0;
   bit            m_blink = 0;

   // Values presented at the next frame start
   logic [NB-1:0] want_states = '0;
   bit            want_cen = 0;
   int            want_crow = 0, want_ccol = 0;

   bit            churn = 0;
   int            chg_y = -1;
   logic [NB-1:0] chg_states = '0;
   int            rst_x = -1, rst_y = -1;
   logic [23:0]   fix_tab[int];

   typedef struct {
      int          due;
      int          x;
      int          y;
      logic [24:0] exp;
      bit          has_fix;
      logic [23:0] fix;
   } exp_t;
   exp_t sb[$];
   bit   rst_edge[int];
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] pal(input int c);
      logic [23:0] t[8] = '{24'h000080, 24'h808080, 24'hFF0000, 24'hFFFFFF,
                            24'h800000, 24'h00FF00, 24'hFFFF00, 24'hFF00FF};
      return t[c];
   endfunction

   function automatic logic [23:0] ref_rgb(input int x, input int y);
      int xc, yc, xo, yo;
      xc = x / CELL_W; if (xc > COLS) xc = COLS;
      yc = y / CELL_H; if (yc > ROWS) yc = ROWS;
      xo = x % CELL_W;
      yo = y % CELL_H;
      if (xc >= COLS || yc >= ROWS) return 24'h000000;
      if (xc == DIV_COL && xo < DIV_W) return 24'h00FFFF;
      if (xo < LINE_W || yo < LINE_W) return 24'h202020;
      if (m_cen && m_blink && yc == m_crow && xc == m_ccol) return 24'hFFA500;
      return pal(int'(m_states[(yc * COLS + xc) * 3 +: 3]));
   endfunction

   function automatic logic [NB-1:0] rnd_states();
      logic [NB-1:0] v;
      for (int i = 0; i < NB; i++) v[i] = 1'($urandom);
      return v;
   endfunction

   function automatic void setcell(input int r, input int c, input int v);
      want_states[(r * COLS + c) * 3 +: 3] = 3'(v);
   endfunction

   // One bus cycle: drive, update the model, queue the expected output.
   task automatic pix(input bit en, input int x, input int y, input bit rst_n = 1'b1);
      exp_t e;
      @(posedge clk); #1;
      reset        = rst_n;
      bus.pixel_en = en;
      bus.hs       = 10'(x);
      bus.vs       = 10'(y);
      if (en && x == 0 && y == 0) begin
         bus.states_flat = want_states;
         bus.cursor_row  = RW'(want_crow);
         bus.cursor_col  = CW'(want_ccol);
         bus.cursor_en   = want_cen;
      end else if (churn && $urandom_range(0, 3) == 0) begin
         bus.states_flat = rnd_states();
         bus.cursor_row  = RW'($urandom);
         bus.cursor_col  = CW'($urandom);
         bus.cursor_en   = 1'($urandom);
      end
      if (!rst_n) begin
         m_states = '0; m_cen = 0; m_crow = 0; m_ccol = 0; m_fcnt = 0; m_blink = 0;
         rst_edge[cyc + 1] = 1'b1;
      end else if (en && x == 0 && y == 0) begin
         m_states = want_states; m_cen = want_cen; m_crow = want_crow; m_ccol = want_ccol;
         if (m_fcnt == BLINK_FRAMES - 1) begin
            m_fcnt = 0;
            m_blink = !m_blink;
         end else begin
            m_fcnt++;
         end
      end
      e.due = cyc + 2;
      e.x = x;
      e.y = y;
      e.exp = en ? {1'b1, ref_rgb(x, y)} : 25'h0;
      e.has_fix = en && fix_tab.exists(y * 1024 + x);
      e.fix = e.has_fix ? fix_tab[y * 1024 + x] : 24'h0;
      sb.push_back(e);
   endtask

   // Output monitor: each queued cycle is compared when it falls due.
   always @(negedge clk) begin
      exp_t e;
      logic [24:0] want;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         want = e.exp;
         if (rst_edge.exists(e.due) || rst_edge.exists(e.due - 1)) want = '0;
         chk($sformatf("pix %0d,%0d", e.x, e.y),
             {7'd0, bus.rgb_valid, bus.r, bus.g, bus.b}, {7'd0, want});
         if (e.has_fix && want[24])
            chk($sformatf("plan %0d,%0d", e.x, e.y), {8'd0, bus.r, bus.g, bus.b}, {8'd0, e.fix});
      end
   end

   task automatic frame(input int last_y);
      for (int y = 0; y <= last_y; y++) begin
         int len;
         len = (y == 97 || y == 150 || y == 200 || y == 250) ? 420 : 2;
         if (y == chg_y) bus.states_flat = chg_states;
         for (int x = 0; x < len; x++) begin
            if ($urandom_range(0, 15) == 0)
               pix(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
            if (y == rst_y && x == rst_x) begin
               pix(1'b1, x, y, 1'b0);
               return;
            end
            pix(1'b1, x, y);
         end
      end
   endtask

   task automatic frame_end();
      repeat (4) pix(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
      chk("blink", {31'd0, bus.blink}, {31'd0, m_blink});
      fix_tab.delete();
   endtask

   initial begin
      bus.pixel_en = 0; bus.hs = 0; bus.vs = 0;
      bus.states_flat = '0; bus.cursor_row = '0; bus.cursor_col = '0; bus.cursor_en = 0;

      // Reset held with live frame-start stimulus
      want_states = rnd_states(); want_cen = 1; want_crow = 1; want_ccol = 1;
      pix(1'b1, 0, 0, 1'b0);
      pix(1'b1, 1, 0, 1'b0);
      pix(1'b1, 2, 0, 1'b0);
      chk("blink_in_reset", {31'd0, bus.blink}, 32'd0);
      repeat (4) pix(1'b0, 0, 0);

      // Zero board after release
      want_states = '0; want_cen = 0;
      fix_tab[150 * 1024 + 100] = 24'h000080;
      frame(160); frame_end();

      // Cell lookup, grid lines, division band
      churn = 1;
      want_states = rnd_states(); want_cen = 0;
      setcell(1, 1, 2); setcell(1, 5, 6);
      fix_tab[150 * 1024 + 100] = 24'hFF0000;
      fix_tab[150 * 1024 + 66]  = 24'h202020;
      fix_tab[97 * 1024 + 100]  = 24'h202020;
      fix_tab[150 * 1024 + 322] = 24'h00FFFF;
      fix_tab[150 * 1024 + 328] = 24'h00FFFF;
      fix_tab[150 * 1024 + 335] = 24'hFFFF00;
      frame(160); frame_end();

      // Mid-frame state change stays hidden until the next frame
      churn = 0;
      setcell(1, 1, 2);
      chg_states = want_states;
      chg_states[(1 * COLS + 1) * 3 +: 3] = 3'd3;
      chg_y = 100;
      fix_tab[150 * 1024 + 100] = 24'hFF0000;
      frame(160); frame_end();
      chg_y = -1;
      want_states = chg_states;
      fix_tab[150 * 1024 + 100] = 24'hFFFFFF;
      frame(160); frame_end();

      // Blinking cursor on cell (2,3)
      churn = 1;
      want_cen = 1; want_crow = 2; want_ccol = 3;
      setcell(2, 3, 4);
      repeat (6) begin
         frame(200); frame_end();
      end

      // Cursor row out of range never draws
      want_crow = 7;
      setcell(2, 3, 5);
      repeat (2) begin
         fix_tab[200 * 1024 + 222] = 24'h00FF00;
         frame(200); frame_end();
      end

      // Random boards and cursors
      repeat (3) begin
         want_states = rnd_states();
         want_cen = 1'($urandom);
         want_crow = $urandom_range(0, 7);
         want_ccol = $urandom_range(0, 15);
         frame(260); frame_end();
      end

      // Reset mid-line, then resynchronise on the next frame
      rst_x = 400; rst_y = 250;
      frame(260); frame_end();
      rst_x = -1; rst_y = -1;
      want_states = rnd_states(); want_cen = 1; want_crow = 0; want_ccol = 0;
      setcell(1, 1, 7);
      fix_tab[150 * 1024 + 100] = 24'hFF00FF;
      frame(160); frame_end();

      repeat (3) @(posedge clk);
      #2;
      chk("drain", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
